// File: rtl/abl_pkg.sv
// Shared definitions for the address-low sequencer: state and mode encodings,
// the address-low op codes and the decoded control bundle.
package abl_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StOpr     = 3'd1,
    StOpr2    = 3'd2,
    StAddr    = 3'd3,
    StBr      = 3'd4,
    StRestore = 3'd5
  } abl_state_e;

  typedef enum logic [2:0] {
    ModeZp     = 3'd0,
    ModeZpx    = 3'd1,
    ModeAbs    = 3'd2,
    ModeAbsx   = 3'd3,
    ModeBranch = 3'd4
  } abl_mode_e;

  // op[3:2] base: 00 zero, 01 PCL, 10 AHL, 11 DB-if-cond.
  // op[1:0] sum : 00 REG+ci, 01 base+REG+ci, 10 base+ci, 11 base+ABL+ci.
  localparam logic [3:0] OpPass    = 4'b0011;  // ABL+ci: hold or step the low byte
  localparam logic [3:0] OpZp      = 4'b1110;  // DB+ci
  localparam logic [3:0] OpZpx     = 4'b1101;  // DB+REG+ci
  localparam logic [3:0] OpAbs     = 4'b1010;  // AHL+ci
  localparam logic [3:0] OpAbsx    = 4'b1001;  // AHL+REG+ci
  localparam logic [3:0] OpBranch  = 4'b1111;  // offset+ABL+ci when taken
  localparam logic [3:0] OpRestore = 4'b0110;  // PCL+ci

  typedef struct packed {
    logic [3:0] op;
    logic       ci;
    logic       cond;
    logic       ld_ahl;
    logic       ld_pc;
    logic       inc_pc;
  } abl_ctrl_t;

  // Codes 5-7 are reserved and never start a sequence.
  function automatic logic mode_valid(input logic [2:0] m);
    return m <= 3'd4;
  endfunction

endpackage

// File: rtl/abl_seq_dec.sv
// Output decode for the address-low sequencer.
// Ports:
//   state_i  - registered sequencer state
//   mode_i   - mode latched at sequence start
//   taken_i  - branch condition, only visible through cond in BR
//   ctrl_o   - op, ci, cond, ld_ahl, ld_pc, inc_pc
module abl_seq_dec
  import abl_pkg::*;
(
  input  abl_state_e state_i,
  input  abl_mode_e  mode_i,
  input  logic       taken_i,
  output abl_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o.op     = OpPass;
    ctrl_o.ci     = 1'b0;
    ctrl_o.cond   = 1'b0;
    ctrl_o.ld_ahl = 1'b0;
    ctrl_o.ld_pc  = 1'b0;
    ctrl_o.inc_pc = 1'b0;
    unique case (state_i)
      StIdle: begin
      end
      StOpr: begin
        ctrl_o.ci     = 1'b1;
        ctrl_o.ld_ahl = 1'b1;
        ctrl_o.ld_pc  = 1'b1;
        ctrl_o.inc_pc = 1'b1;
      end
      StOpr2: begin
        ctrl_o.ci     = 1'b1;
        ctrl_o.ld_pc  = 1'b1;
        ctrl_o.inc_pc = 1'b1;
      end
      StAddr: begin
        ctrl_o.ld_pc  = 1'b1;
        ctrl_o.inc_pc = 1'b1;
        unique case (mode_i)
          ModeZp: begin
            ctrl_o.op   = OpZp;
            ctrl_o.cond = 1'b1;
          end
          ModeZpx: begin
            ctrl_o.op   = OpZpx;
            ctrl_o.cond = 1'b1;
          end
          ModeAbs:  ctrl_o.op = OpAbs;
          ModeAbsx: ctrl_o.op = OpAbsx;
          // Branch never reaches ADDR; fall back to the idle vector.
          default: begin
            ctrl_o.ld_pc  = 1'b0;
            ctrl_o.inc_pc = 1'b0;
          end
        endcase
      end
      StBr: begin
        ctrl_o.op     = OpBranch;
        ctrl_o.ci     = 1'b1;
        ctrl_o.cond   = taken_i;
        ctrl_o.ld_pc  = 1'b1;
        ctrl_o.inc_pc = 1'b1;
      end
      StRestore: ctrl_o.op = OpRestore;
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/abl_seq.sv
// Address-low sequencer: steps through operand fetch, effective-address
// formation and PC restore for ZP/ZPX/ABS/ABSX/BRANCH addressing.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   rdy, halt       - state advances only when rdy=1 and halt=0
//   start, mode     - launch request and addressing mode (sampled in IDLE)
//   taken, co       - branch condition, address-low adder carry out
//   op, ci, cond    - adder operation, carry input, base qualifier
//   ld_ahl, ld_pc, inc_pc - register load strobes
//   busy, done      - sequence active, final-cycle pulse
//   page_x          - carry captured from the index or branch add
module abl_seq
  import abl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic       halt,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       taken,
  input  logic       co,
  output logic [3:0] op,
  output logic       ci,
  output logic       cond,
  output logic       ld_ahl,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       busy,
  output logic       done,
  output logic       page_x
);

  abl_state_e state_q, state_d;
  abl_mode_e  mode_q, mode_d;
  logic       page_x_q, page_x_d;
  logic       adv;
  abl_ctrl_t  ctrl;

  assign adv = rdy & ~halt;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    page_x_d = page_x_q;
    if (adv) begin
      unique case (state_q)
        StIdle: begin
          if (start && mode_valid(mode)) begin
            state_d  = StOpr;
            mode_d   = abl_mode_e'(mode);
            page_x_d = 1'b0;
          end
        end
        StOpr: begin
          if (mode_q == ModeAbs || mode_q == ModeAbsx) begin
            state_d = StOpr2;
          end else if (mode_q == ModeBranch) begin
            state_d = StBr;
          end else begin
            state_d = StAddr;
          end
        end
        StOpr2: state_d = StAddr;
        StAddr: begin
          state_d = StRestore;
          if (mode_q == ModeAbsx) begin
            page_x_d = co;
          end
        end
        StBr: begin
          state_d  = StIdle;
          page_x_d = co;
        end
        StRestore: state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mode_q   <= ModeZp;
      page_x_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      page_x_q <= page_x_d;
    end
  end

  abl_seq_dec u_dec (
    .state_i (state_q),
    .mode_i  (mode_q),
    .taken_i (taken),
    .ctrl_o  (ctrl)
  );

  assign op     = ctrl.op;
  assign ci     = ctrl.ci;
  assign cond   = ctrl.cond;
  assign ld_ahl = ctrl.ld_ahl;
  assign ld_pc  = ctrl.ld_pc;
  assign inc_pc = ctrl.inc_pc;
  assign busy   = (state_q != StIdle);
  assign page_x = page_x_q;

  // Qualified by the advance so a stalled final state cannot pulse twice;
  // gated by reset so an aborted sequence never reports completion.
  assign done = ((state_q == StRestore) || (state_q == StBr)) & adv & ~reset;

endmodule

// File: tb/tb_abl_seq.sv
// Scoreboard bench for abl_seq: stimulus pushes one expected record per
// sequence; the monitor accumulates per-advance outputs and compares on done.
module tb_abl_seq;

  logic       clk = 1'b0;
  logic       reset, rdy, halt, start, taken, co;
  logic [2:0] mode;
  logic [3:0] op;
  logic       ci, cond, ld_ahl, ld_pc, inc_pc, busy, done, page_x;

  abl_seq dut (
    .clk    (clk),
    .reset  (reset),
    .rdy    (rdy),
    .halt   (halt),
    .start  (start),
    .mode   (mode),
    .taken  (taken),
    .co     (co),
    .op     (op),
    .ci     (ci),
    .cond   (cond),
    .ld_ahl (ld_ahl),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .busy   (busy),
    .done   (done),
    .page_x (page_x)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ops;   // op per advance, oldest in the high nibble
    int          n;     // advances from OPR through the done cycle
    logic [3:0]  cis;   // ci per advance, oldest in the high bit
    logic        cond;  // cond in the done cycle
    logic        px;    // page_x after the sequence
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;
  int   n_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] outv();
    return {op, ci, cond, ld_ahl, ld_pc, inc_pc, busy, done, page_x};
  endfunction

  task automatic push(input logic [15:0] ops, input int n, input logic [3:0] cis,
                      input logic cnd, input logic px);
    exp_t e;
    e.ops  = ops;
    e.n    = n;
    e.cis  = cis;
    e.cond = cnd;
    e.px   = px;
    exp_q.push_back(e);
    n_exp++;
  endtask

  // Monitor
  logic [15:0] m_ops = '0;
  int          m_n   = 0;
  logic [3:0]  m_cis = '0;
  int          m_ld  = 0;
  logic        pchk  = 1'b0;
  logic        exp_px = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (pchk) begin
      check("page_x_after_seq", {31'd0, page_x}, {31'd0, exp_px});
      pchk = 1'b0;
    end
    if (reset || busy !== 1'b1) begin
      m_ops = '0;
      m_n   = 0;
      m_cis = '0;
      m_ld  = 0;
    end else if (rdy && !halt) begin
      m_ops = {m_ops[11:0], op};
      m_cis = {m_cis[2:0], ci};
      m_n++;
      m_ld += int'(ld_ahl);
    end
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (no sequence pending)");
      end else begin
        e = exp_q.pop_front();
        check("op_trace", {16'd0, m_ops}, {16'd0, e.ops});
        check("advance_count", m_n, e.n);
        check("ci_trace", {28'd0, m_cis}, {28'd0, e.cis});
        check("cond_at_done", {31'd0, cond}, {31'd0, e.cond});
        check("ld_ahl_count", m_ld, 1);
        pchk   = 1'b1;
        exp_px = e.px;
      end
    end
  end

  // Called at posedge+1 in IDLE; returns at posedge+1 in OPR.
  task automatic launch(input logic [2:0] m, input logic tk, input logic c);
    start = 1'b1;
    mode  = m;
    taken = tk;
    co    = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy !== 1'b0 && k < 20);
    check("wait_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat;
    reset = 1'b1; rdy = 1'b1; halt = 1'b0; start = 1'b0;
    mode  = 3'd0; taken = 1'b0; co = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_reset_vec", {20'd0, outv()}, 32'h300);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_vec", {20'd0, outv()}, 32'h300);
    @(posedge clk);
    #1;

    // ZP with co=1: page_x must not load
    push(16'h03E6, 3, 4'b0100, 1'b0, 1'b0);
    launch(3'd0, 1'b0, 1'b1);
    wait_idle();
    // ZPX
    push(16'h03D6, 3, 4'b0100, 1'b0, 1'b0);
    launch(3'd1, 1'b0, 1'b0);
    wait_idle();
    // ABS with co=1: no capture
    push(16'h33A6, 4, 4'b1100, 1'b0, 1'b0);
    launch(3'd2, 1'b0, 1'b1);
    wait_idle();
    // ABSX with co=1 in ADDR
    push(16'h3396, 4, 4'b1100, 1'b0, 1'b1);
    launch(3'd3, 1'b0, 1'b1);
    wait_idle();
    // ZP after page_x=1: cleared on entry to OPR
    push(16'h03E6, 3, 4'b0100, 1'b0, 1'b0);
    launch(3'd0, 1'b0, 1'b1);
    wait_idle();
    // BRANCH not taken, then taken with carry
    push(16'h003F, 2, 4'b0011, 1'b0, 1'b0);
    launch(3'd4, 1'b0, 1'b0);
    wait_idle();
    push(16'h003F, 2, 4'b0011, 1'b1, 1'b1);
    launch(3'd4, 1'b1, 1'b1);
    wait_idle();

    // BRANCH with one halted cycle in BR: no done while halted
    push(16'h003F, 2, 4'b0011, 1'b1, 1'b0);
    launch(3'd4, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    halt = 1'b1;
    @(negedge clk);
    check("br_halt_vec", {20'd0, outv()}, 32'hFDC);
    @(posedge clk);
    #1;
    halt = 1'b0;
    wait_idle();

    // ABSX with rdy low for 3 cycles in OPR2
    push(16'h3396, 4, 4'b1100, 1'b0, 1'b1);
    launch(3'd3, 1'b0, 1'b1);
    @(negedge clk);
    check("opr_vec", {20'd0, outv()}, 32'h3BC);
    @(posedge clk);
    #1;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("opr2_stall_vec", {20'd0, outv()}, 32'h39C);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    wait_idle();

    // Reset in ADDR aborts without done
    launch(3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_abort_vec", {20'd0, outv()}, 32'h300);
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Reserved mode stays idle
    start = 1'b1;
    mode  = 3'd6;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 3'd0;
    @(negedge clk);
    check("reserved_mode_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // start held: second ZP begins only after one IDLE cycle
    push(16'h03E6, 3, 4'b0100, 1'b0, 1'b0);
    push(16'h03E6, 3, 4'b0100, 1'b0, 1'b0);
    start = 1'b1;
    mode  = 3'd0;
    co    = 1'b0;
    @(posedge clk);
    #1;
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      pat = {pat[5:0], busy};
      @(posedge clk);
      #1;
      if (i == 4) start = 1'b0;
    end
    check("held_start_busy_pattern", {25'd0, pat}, {25'd0, 7'b1110111});
    wait_idle();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("done_count", n_done, n_exp);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/abl_seq.md
ABL_SEQ -- requirements
Module: abl_seq

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  — single clock, all state updates on rising edge.
- reset  in  1  — synchronous, active-high.
- rdy  in  1  — bus ready; state advances only when rdy=1 and halt=0.
- halt  in  1  — stall request; freezes the sequencer.
- start  in  1  — begin an address sequence; sampled only in IDLE.
- mode  in  3  — addressing mode, sampled with start:
  - 0 = ZP, 1 = ZPX, 2 = ABS, 3 = ABSX, 4 = BRANCH.
  - 5–7 are reserved.
- taken  in  1  — branch condition, used in the BR state.
- co  in  1  — carry out from the address-low adder.
- op  out  4  — address-low operation code (encoding in REQ-020).
- ci  out  1  — adder carry input.
- cond  out  1  — base-select qualifier.
- ld_ahl  out  1  — load address-hold register from DB.
- ld_pc  out  1  — load PCL.
- inc_pc  out  1  — increment applied on PCL load.
- busy  out  1  — high in any state other than IDLE.
- done  out  1  — one-cycle pulse marking the final cycle of a sequence.
- page_x  out  1  — registered carry captured from the index or branch add.

Function
REQ-010 States SHALL be IDLE, OPR, OPR2, ADDR, BR, RESTORE, encoded in 3 bits.
REQ-011 An advance SHALL mean a rising clk edge with rdy=1 and halt=0.
- With no advance, state, page_x and latched mode SHALL hold.
- Outputs SHALL remain those of the current state.
REQ-012 In IDLE, start=1 with mode 0–4 SHALL latch mode and advance to OPR; start=0 or mode 5–7 SHALL remain in IDLE.
REQ-013 Transitions SHALL be:
- OPR goes to OPR2 for ABS/ABSX, to BR for BRANCH, otherwise to ADDR.
- OPR2 goes to ADDR.
- ADDR goes to RESTORE.
- BR goes to IDLE.
- RESTORE goes to IDLE.
REQ-014 Output vectors (op, ci, cond, ld_ahl, ld_pc, inc_pc) SHALL be, per state:
- IDLE: 0011, 0, 0, 0, 0, 0.
- OPR: 0011, 1, 0, 1, 1, 1.
- OPR2: 0011, 1, 0, 0, 1, 1.
- ADDR by mode:
  - ZP: 1110, 0, 1, 0, 1, 1.
  - ZPX: 1101, 0, 1, 0, 1, 1.
  - ABS: 1010, 0, 0, 0, 1, 1.
  - ABSX: 1001, 0, 0, 0, 1, 1.
- BR: 1111, 1, taken, 0, 1, 1.
- RESTORE: 0110, 0, 0, 0, 0, 0.
REQ-015 In ADDR for ABSX and in BR, page_x SHALL load co on advance.
- page_x SHALL clear on entry to OPR.
- page_x SHALL otherwise hold.
REQ-016 done SHALL be combinationally high in RESTORE and in BR; it SHALL be qualified by rdy and ~halt so that it pulses exactly once per sequence.
REQ-017 busy SHALL be 0 only in IDLE.
REQ-018 Sequence lengths in advances SHALL be:
- ZP/ZPX: 3.
- ABS/ABSX: 4.
- BRANCH: 2.
REQ-019 start asserted while busy SHALL be ignored; there is no queueing.
REQ-020 op encoding:
- op[3:2] selects the base: 00 = zero, 01 = PCL, 10 = AHL, 11 = DB if cond else zero.
- op[1:0] selects the sum: 00 = REG+ci, 01 = base+REG+ci, 10 = base+ci, 11 = base+ABL+ci.
REQ-021 Outputs SHALL be decoded from registered state and latched mode only, with no input-to-output paths, except cond (from taken) and done (from rdy/halt).

Reset
REQ-030 reset=1 at a clk edge SHALL force IDLE, mode=0 and page_x=0, regardless of rdy/halt.
REQ-031 While in reset and in the cycle after, outputs SHALL equal the IDLE vector, with busy=0 and done=0.
REQ-032 reset mid-sequence SHALL abort without emitting done.

Structure
REQ-040 State encodings, mode codes and op constants SHALL live in a shared package abl_pkg.
REQ-041 The output decode SHALL be a single always block in this module; no sub-module is required, though the decode MAY be split into a combinational abl_seq_dec.

Verification
REQ-050 The bench SHALL cover these directed scenarios:
- ZP: start, mode=0 → op sequence 0011/0011/1110/0110; done in the 3rd advance; busy for 3 cycles.
- ABSX, co=1 during ADDR → ADDR op=1001; page_x=1 after ADDR; ld_ahl=1 only in OPR; done at the 4th advance.
- BRANCH with taken=0, then taken=1 → BR cond=0 then 1, op=1111, ci=1; 2-cycle sequence; no RESTORE.
- rdy=0 for 3 cycles during OPR2 → state, page_x and outputs frozen; the sequence completes afterward with a single done.
- reset asserted in ADDR → next cycle IDLE, busy=0, no done; start with mode=6 stays in IDLE.
- start held high through a sequence → a new sequence begins only after return to IDLE.
